// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, writeback.
// Drives instruction-memory handshake, datapath controls and a retired counter.
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [5:0]         Op_i,
  input  logic               imem_ack_i,
  output logic               imem_req_o,
  output logic               IRWrite_o,
  output logic               PCWrite_o,
  output logic               RegDst_o,
  output logic               ALUSrc_o,
  output logic [1:0]         ALUOp_o,
  output logic               RegWrite_o,
  output logic               illegal_o,
  output logic [2:0]         state_o,
  output logic [COUNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t       state;
  state_t       state_next;
  logic [5:0]   op_q;
  logic         op_legal;

  assign op_legal = (Op_i == OP_RTYPE) || (Op_i == OP_ADDI);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      op_q      <= 6'd0;
      retired_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        op_q <= Op_i;
        if (!op_legal) illegal_o <= 1'b1;
      end
      if (state == WB) retired_o <= retired_o + COUNT_W'(1);
    end
  end

  // Strobes are combinational from state; datapath controls only in EXEC/WB.
  always_comb begin
    state_next = IDLE;
    imem_req_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    RegDst_o   = 1'b0;
    ALUSrc_o   = 1'b0;
    ALUOp_o    = 2'b00;
    RegWrite_o = 1'b0;
    case (state)
      IDLE:   state_next = start_i ? FETCH : IDLE;
      FETCH: begin
        imem_req_o = 1'b1;
        IRWrite_o  = imem_ack_i;
        PCWrite_o  = imem_ack_i;
        state_next = imem_ack_i ? DECODE : FETCH;
      end
      DECODE: state_next = op_legal ? EXEC : HALT;
      EXEC, WB: begin
        if (op_q == OP_RTYPE) begin
          RegDst_o = 1'b1;
          ALUOp_o  = 2'b11;
        end else begin
          ALUSrc_o = 1'b1;
        end
        if (state == WB) begin
          RegWrite_o = 1'b1;
          state_next = stop_i ? IDLE : FETCH;
        end else begin
          state_next = WB;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control, using a per-instruction
// transaction model (fetch wait count, opcode, stop) to predict every cycle.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk_i;
  logic          rst_i;
  logic          start_i;
  logic          stop_i;
  logic [5:0]    Op_i;
  logic          imem_ack_i;
  logic          imem_req_o;
  logic          IRWrite_o;
  logic          PCWrite_o;
  logic          RegDst_o;
  logic          ALUSrc_o;
  logic [1:0]    ALUOp_o;
  logic          RegWrite_o;
  logic          illegal_o;
  logic [2:0]    state_o;
  logic [CW-1:0] retired_o;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  multicycle_control #(.COUNT_W(CW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .Op_i       (Op_i),
    .imem_ack_i (imem_ack_i),
    .imem_req_o (imem_req_o),
    .IRWrite_o  (IRWrite_o),
    .PCWrite_o  (PCWrite_o),
    .RegDst_o   (RegDst_o),
    .ALUSrc_o   (ALUSrc_o),
    .ALUOp_o    (ALUOp_o),
    .RegWrite_o (RegWrite_o),
    .illegal_o  (illegal_o),
    .state_o    (state_o),
    .retired_o  (retired_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic checkAll(input string tag, input int st, input bit req, input bit irw,
                          input bit pcw, input bit rd, input bit as, input int aop,
                          input bit rw, input bit ill);
    checkOutput({tag, ".state"},   32'(state_o),    32'(st));
    checkOutput({tag, ".req"},     32'(imem_req_o), 32'(req));
    checkOutput({tag, ".irwrite"}, 32'(IRWrite_o),  32'(irw));
    checkOutput({tag, ".pcwrite"}, 32'(PCWrite_o),  32'(pcw));
    checkOutput({tag, ".regdst"},  32'(RegDst_o),   32'(rd));
    checkOutput({tag, ".alusrc"},  32'(ALUSrc_o),   32'(as));
    checkOutput({tag, ".aluop"},   32'(ALUOp_o),    32'(aop));
    checkOutput({tag, ".regwrite"},32'(RegWrite_o), 32'(rw));
    checkOutput({tag, ".illegal"}, 32'(illegal_o),  32'(ill));
    checkOutput({tag, ".retired"}, 32'(retired_o),  32'(exp_retired));
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit a, input logic [5:0] o);
    start_i    = s;
    stop_i     = p;
    imem_ack_i = a;
    Op_i       = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [5:0] randOp();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic doReset();
    rst_i = 1'b0;
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), randOp());
    tick();
    rst_i = 1'b1;
    exp_retired = 0;
  endtask

  // Sit in IDLE for n cycles (stray inputs allowed), then start into FETCH.
  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), randOp());
      checkAll("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), randOp());
    checkAll("idle_start", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // Predicts one instruction starting in FETCH; returns halted on illegal opcode.
  task automatic runInstr(input int waits, input logic [5:0] op, input bit stop_b,
                          output bit halted);
    bit is_r;
    bit legal;
    is_r   = (op == 6'b000000);
    legal  = is_r || (op == 6'b001000);
    halted = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      bit a;
      a = (i == waits);
      applyStimulus(1'($urandom), 1'($urandom), a, randOp());
      checkAll("fetch", 1, 1, a, a, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), op);
    checkAll("decode", 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if (!legal) begin
      halted = 1'b1;
      for (int i = 0; i < 20; i++) begin
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), randOp());
        checkAll("halt", 5, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
      end
      return;
    end
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), randOp());
    checkAll("exec", 3, 0, 0, 0, is_r, !is_r, is_r ? 3 : 0, 0, 0);
    tick();
    applyStimulus(1'($urandom), stop_b, 1'($urandom), randOp());
    checkAll("wb", 4, 0, 0, 0, is_r, !is_r, is_r ? 3 : 0, 1, 0);
    tick();
    exp_retired = (exp_retired + 1) % (1 << CW);
  endtask

  initial begin
    bit h;
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 6'd0);
    @(negedge clk_i);

    doReset();
    applyStimulus(0, 0, 1, 6'd0);
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // R-type with immediate ack, then stop back to IDLE.
    runIdle(1);
    runInstr(0, 6'b000000, 1'b1, h);
    checkOutput("rtype.retired", 32'(retired_o), 32'd1);

    // addi with three wait cycles, then back-to-back R/addi pair with stop on the second.
    runIdle(2);
    runInstr(3, 6'b001000, 1'b0, h);
    runInstr(0, 6'b000000, 1'b0, h);
    runInstr(1, 6'b001000, 1'b1, h);
    runIdle(3);

    // Reset during FETCH with ack high: no strobes after the edge.
    runInstr(0, 6'b000000, 1'b0, h);
    rst_i = 1'b0;
    applyStimulus(1, 0, 1, 6'd0);
    tick();
    rst_i = 1'b1;
    exp_retired = 0;
    applyStimulus(0, 0, 1, 6'd0);
    checkAll("rst_fetch", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Sixteen instructions wrap the 4-bit counter back to zero.
    runIdle(0);
    for (int i = 0; i < 16; i++) begin
      runInstr(int'($urandom_range(0, 2)), ($urandom_range(0, 1) != 0) ? 6'b001000 : 6'b000000,
               i == 15, h);
      if (i == 14) checkOutput("wrap.pre", 32'(retired_o), 32'd15);
    end
    checkOutput("wrap.zero", 32'(retired_o), 32'd0);

    // Illegal opcode halts; reset clears the flag.
    runIdle(1);
    runInstr(0, 6'b100011, 1'b0, h);
    checkOutput("illegal.halted", 32'(h), 32'd1);
    doReset();
    applyStimulus(0, 0, 0, 6'd0);
    checkAll("illegal_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Random program: mostly legal opcodes, occasional illegal or stop.
    runIdle(0);
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      bit stop_b;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        op = randOp();
        if (op == 6'b000000 || op == 6'b001000) op = 6'b111111;
      end else begin
        op = (r < 5) ? 6'b000000 : 6'b001000;
      end
      stop_b = ($urandom_range(0, 5) == 0);
      runInstr(int'($urandom_range(0, 3)), op, stop_b, h);
      if (h) begin
        doReset();
        runIdle(int'($urandom_range(0, 2)));
      end else if (stop_b) begin
        runIdle(int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
